// File: rtl/atan_arbiter.sv
// atan_arbiter: shares one fixed-latency Atan unit between two requesters.
// Each requester holds credits covering its in-flight operations and its
// buffered results, so a stalled response consumer only blocks itself.
// Optional build macro: ATAN_ARB_FIXED_PRIO_EN (requester 0 always wins
// contention); when undefined, contention is resolved round-robin.
// LATENCY must be at least 1.
module atan_arbiter #(
  parameter int LATENCY    = 17,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        io_req0_valid,
  output logic        io_req0_ready,
  input  logic [31:0] io_req0_bits,
  input  logic        io_req1_valid,
  output logic        io_req1_ready,
  input  logic [31:0] io_req1_bits,
  output logic        io_resp0_valid,
  input  logic        io_resp0_ready,
  output logic [31:0] io_resp0_bits,
  output logic        io_resp1_valid,
  input  logic        io_resp1_ready,
  output logic [31:0] io_resp1_bits,
  output logic [31:0] io_atan_in,
  input  logic [31:0] io_atan_out
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic [1:0]       req_valid, resp_ready, elig, issue, push, pop, resp_valid;
  logic [1:0][31:0] req_bits, resp_bits;
  logic             rst_q, blank, grant_valid, grant_id;
  logic [LATENCY-1:0] tag_v, tag_id;

  assign req_valid  = {io_req1_valid, io_req0_valid};
  assign req_bits   = {io_req1_bits, io_req0_bits};
  assign resp_ready = {io_resp1_ready, io_resp0_ready};

  // No issue while reset is asserted nor in the first cycle after it.
  assign blank = reset | rst_q;

  // Remember that the previous cycle was a reset cycle.
  always_ff @(posedge clock) begin
    rst_q <= reset;
  end

`ifndef ATAN_ARB_FIXED_PRIO_EN
  logic last_grant;

  // Round-robin history; starts at 1 so requester 0 wins first contention.
  always_ff @(posedge clock) begin
    if (reset) begin
      last_grant <= 1'b1;
    end else if (grant_valid) begin
      last_grant <= grant_id;
    end
  end
`endif

  // Pick at most one eligible requester per cycle.
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = 1'b0;
    if (elig[0] && elig[1]) begin
      grant_valid = 1'b1;
`ifdef ATAN_ARB_FIXED_PRIO_EN
      grant_id    = 1'b0;
`else
      grant_id    = ~last_grant;
`endif
    end else if (elig[0]) begin
      grant_valid = 1'b1;
      grant_id    = 1'b0;
    end else if (elig[1]) begin
      grant_valid = 1'b1;
      grant_id    = 1'b1;
    end
  end

  assign issue         = {grant_valid & grant_id, grant_valid & ~grant_id};
  assign io_req0_ready = issue[0];
  assign io_req1_ready = issue[1];
  assign io_atan_in    = grant_valid ? req_bits[grant_id] : 32'h0;

  // Tag shift register tracks which requester owns each Atan pipeline slot.
  always_ff @(posedge clock) begin
    if (reset) begin
      tag_v  <= '0;
      tag_id <= '0;
    end else begin
      for (int i = LATENCY - 1; i > 0; i--) begin
        tag_v[i]  <= tag_v[i-1];
        tag_id[i] <= tag_id[i-1];
      end
      tag_v[0]  <= grant_valid;
      tag_id[0] <= grant_id;
    end
  end

  assign push = {tag_v[LATENCY-1] & tag_id[LATENCY-1],
                 tag_v[LATENCY-1] & ~tag_id[LATENCY-1]};

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  for (genvar n = 0; n < 2; n++) begin : g_req
    logic [31:0]   mem [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] fcnt, cnt;

    assign resp_valid[n] = !reset && (fcnt != '0);
    assign resp_bits[n]  = resp_valid[n] ? mem[rd_ptr] : 32'h0;
    assign pop[n]        = resp_valid[n] & resp_ready[n];
    assign elig[n]       = !blank && req_valid[n] && (cnt < CW'(FIFO_DEPTH));

    // Result storage; contents are qualified by fcnt so it needs no reset.
    always_ff @(posedge clock) begin
      if (push[n]) begin
        mem[wr_ptr] <= io_atan_out;
      end
    end

    // Response FIFO pointers and occupancy.
    always_ff @(posedge clock) begin
      if (reset) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        fcnt   <= '0;
      end else begin
        if (push[n]) wr_ptr <= ptr_inc(wr_ptr);
        if (pop[n])  rd_ptr <= ptr_inc(rd_ptr);
        case ({push[n], pop[n]})
          2'b10:   fcnt <= fcnt + 1'b1;
          2'b01:   fcnt <= fcnt - 1'b1;
          default: fcnt <= fcnt;
        endcase
      end
    end

    // Credit counter: in-flight plus buffered results of this requester.
    always_ff @(posedge clock) begin
      if (reset) begin
        cnt <= '0;
      end else begin
        case ({issue[n], pop[n]})
          2'b10:   cnt <= cnt + 1'b1;
          2'b01:   cnt <= cnt - 1'b1;
          default: cnt <= cnt;
        endcase
      end
    end
  end

  assign io_resp0_valid = resp_valid[0];
  assign io_resp1_valid = resp_valid[1];
  assign io_resp0_bits  = resp_bits[0];
  assign io_resp1_bits  = resp_bits[1];

endmodule

// File: tb/tb_atan_arbiter.sv
// Testbench for atan_arbiter: directed stimulus, a transaction-level model
// (per-requester queues of pending results with their earliest visible
// cycle) checked against every DUT output each cycle, plus literal checks.
module tb_atan_arbiter;
  localparam int LAT = 17;
  localparam int DEP = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        io_req0_valid, io_req0_ready, io_req1_valid, io_req1_ready;
  logic [31:0] io_req0_bits, io_req1_bits;
  logic        io_resp0_valid, io_resp0_ready, io_resp1_valid, io_resp1_ready;
  logic [31:0] io_resp0_bits, io_resp1_bits;
  logic [31:0] io_atan_in, io_atan_out;

  always #5 clock = ~clock;

  atan_arbiter #(.LATENCY(LAT), .FIFO_DEPTH(DEP)) dut (
    .clock(clock), .reset(reset),
    .io_req0_valid(io_req0_valid), .io_req0_ready(io_req0_ready), .io_req0_bits(io_req0_bits),
    .io_req1_valid(io_req1_valid), .io_req1_ready(io_req1_ready), .io_req1_bits(io_req1_bits),
    .io_resp0_valid(io_resp0_valid), .io_resp0_ready(io_resp0_ready), .io_resp0_bits(io_resp0_bits),
    .io_resp1_valid(io_resp1_valid), .io_resp1_ready(io_resp1_ready), .io_resp1_bits(io_resp1_bits),
    .io_atan_in(io_atan_in), .io_atan_out(io_atan_out)
  );

  typedef struct {
    int          rdy;
    logic [31:0] val;
  } ent_t;

  ent_t        q0[$], q1[$];
  logic [31:0] atan_pipe[$];
  int          checks = 0, failures = 0, cyc = 0;
  bit          m_last = 1'b1, m_blank = 1'b0;
  int          iss0_cnt = 0, rv0_cnt = 0;

  // Stand-in for the Atan unit: exact value for 1.0, a reversible scramble otherwise.
  function automatic logic [31:0] atan_f(input logic [31:0] x);
    if (x == 32'h3f800000) return 32'h3f490fdb;
    return {x[15:0], x[31:16]} ^ 32'h1234_5678;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  // One clock cycle: drive Atan output, compare all outputs to the model, advance model.
  task automatic tick();
    logic        e_rv0, e_rv1, el0, el1, g_v, g_id;
    logic [31:0] e_rb0, e_rb1, e_ain;
    ent_t        e;
    io_atan_out = (atan_pipe.size() >= LAT) ? atan_f(atan_pipe.pop_front()) : 32'h0;
    #2;
    e_rv0 = 1'b0; e_rv1 = 1'b0; e_rb0 = 32'h0; e_rb1 = 32'h0;
    g_v = 1'b0; g_id = 1'b0; e_ain = 32'h0;
    if (!reset) begin
      if (q0.size() > 0 && q0[0].rdy <= cyc) begin e_rv0 = 1'b1; e_rb0 = q0[0].val; end
      if (q1.size() > 0 && q1[0].rdy <= cyc) begin e_rv1 = 1'b1; e_rb1 = q1[0].val; end
      el0 = !m_blank && io_req0_valid && (q0.size() < DEP);
      el1 = !m_blank && io_req1_valid && (q1.size() < DEP);
      if (el0 && el1) begin
        g_v = 1'b1;
`ifdef ATAN_ARB_FIXED_PRIO_EN
        g_id = 1'b0;
`else
        g_id = !m_last;
`endif
      end else if (el0) begin
        g_v = 1'b1; g_id = 1'b0;
      end else if (el1) begin
        g_v = 1'b1; g_id = 1'b1;
      end
      if (g_v) e_ain = g_id ? io_req1_bits : io_req0_bits;
    end
    chk("req0_ready", 32'(io_req0_ready), 32'(g_v && !g_id));
    chk("req1_ready", 32'(io_req1_ready), 32'(g_v && g_id));
    chk("resp0_valid", 32'(io_resp0_valid), 32'(e_rv0));
    chk("resp1_valid", 32'(io_resp1_valid), 32'(e_rv1));
    chk("resp0_bits", io_resp0_bits, e_rb0);
    chk("resp1_bits", io_resp1_bits, e_rb1);
    chk("atan_in", io_atan_in, e_ain);
    if (io_req0_valid && io_req0_ready) iss0_cnt++;
    if (io_resp0_valid) rv0_cnt++;
    if (reset) begin
      q0.delete(); q1.delete();
      m_last = 1'b1; m_blank = 1'b1;
    end else begin
      if (e_rv0 && io_resp0_ready) void'(q0.pop_front());
      if (e_rv1 && io_resp1_ready) void'(q1.pop_front());
      if (g_v) begin
        e.rdy = cyc + LAT + 1;
        e.val = atan_f(e_ain);
        if (g_id) q1.push_back(e); else q0.push_back(e);
        m_last = g_id;
      end
      m_blank = 1'b0;
    end
    atan_pipe.push_back(io_atan_in);
    cyc++;
    @(negedge clock);
  endtask

  initial begin
    reset = 1'b1;
    io_req0_valid = 1'b1; io_req1_valid = 1'b1;
    io_req0_bits = 32'h0000_1111; io_req1_bits = 32'h0000_2222;
    io_resp0_ready = 1'b1; io_resp1_ready = 1'b1;
    io_atan_out = 32'h0;
    @(negedge clock);

    // Reset with requests pending, then the blank cycle after reset.
    repeat (3) tick();
    reset = 1'b0;
    #1 chk("blank_ready0", 32'(io_req0_ready), 32'd0);
    tick();
    io_req0_valid = 1'b0; io_req1_valid = 1'b0;
    repeat (2) tick();

    // Single operand 1.0 from requester 0: result visible 18 cycles later.
    io_req0_valid = 1'b1; io_req0_bits = 32'h3f800000;
    tick();
    io_req0_valid = 1'b0;
    repeat (16) tick();
    #1 chk("lat_resp0_valid_c17", 32'(io_resp0_valid), 32'd0);
    tick();
    #1 chk("lat_resp0_valid_c18", 32'(io_resp0_valid), 32'd1);
    chk("lat_resp0_bits_c18", io_resp0_bits, 32'h3f490fdb);
    repeat (5) tick();

    // Both requesters streaming with free consumers.
    io_req0_valid = 1'b1; io_req1_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      io_req0_bits = 32'h1000_0000 + 32'(i);
      io_req1_bits = 32'h2000_0000 + 32'(i);
      if (i == 0) begin
`ifdef ATAN_ARB_FIXED_PRIO_EN
        #1 chk("rr_first_grant1", 32'(io_req1_ready), 32'd0);
`else
        #1 chk("rr_first_grant1", 32'(io_req1_ready), 32'd1);
`endif
      end
      tick();
    end
    io_req0_valid = 1'b0; io_req1_valid = 1'b0;
    repeat (25) tick();

    // Requester 0 consumer stalled: exactly 4 issues, requester 1 unaffected.
    io_resp0_ready = 1'b0;
    io_req0_valid = 1'b1; io_req1_valid = 1'b1;
    iss0_cnt = 0;
    for (int i = 0; i < 37; i++) begin
      io_req0_bits = 32'h3000_0000 + 32'(i);
      io_req1_bits = 32'h4000_0000 + 32'(i);
      tick();
    end
    chk("req0_issues_stalled", 32'(iss0_cnt), 32'd4);

    // Pop while full: no issue that cycle, one issue the next.
    io_req1_valid = 1'b0; io_resp0_ready = 1'b1;
    io_req0_bits = 32'h5000_0000;
    #1 chk("full_pop_valid", 32'(io_resp0_valid), 32'd1);
    chk("full_pop_ready0", 32'(io_req0_ready), 32'd0);
    tick();
    io_resp0_ready = 1'b0;
    io_req0_bits = 32'h5000_0001;
    #1 chk("after_pop_ready0", 32'(io_req0_ready), 32'd1);
    iss0_cnt = 0;
    tick();
    io_req1_valid = 1'b1;
    repeat (10) tick();
    chk("req0_issues_after_pop", 32'(iss0_cnt), 32'd1);
    io_req0_valid = 1'b0; io_req1_valid = 1'b0;
    io_resp0_ready = 1'b1; io_resp1_ready = 1'b1;
    repeat (30) tick();

    // Reset in mid-operation discards three in-flight operands.
    io_req0_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      io_req0_bits = 32'h6000_0000 + 32'(i);
      tick();
    end
    io_req0_valid = 1'b0;
    repeat (5) tick();
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    io_req0_valid = 1'b1; io_req1_valid = 1'b1;
    io_req0_bits = 32'h7000_0000; io_req1_bits = 32'h7100_0000;
    #1 chk("post_rst_blank_ready0", 32'(io_req0_ready), 32'd0);
    tick();
    #1 chk("post_rst_ready0", 32'(io_req0_ready), 32'd1);
    chk("post_rst_ready1", 32'(io_req1_ready), 32'd0);
    tick();
    io_req0_valid = 1'b0; io_req1_valid = 1'b0;
    rv0_cnt = 0;
    repeat (40) tick();
    chk("post_rst_resp0_count", 32'(rv0_cnt), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/atan_arbiter.md
ATAN_ARBITER -- requirements
Module: atan_arbiter

Interface
REQ-001 Parameter LATENCY, default 17: cycles from operand on io_atan_in to matching result on io_atan_out of the shared Atan unit.
REQ-002 Parameter FIFO_DEPTH, default 4: per-requester response buffer depth and max outstanding operations per requester.
REQ-003 clock  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 io_req0_valid / io_req1_valid  input  1  requester N operand valid.
REQ-006 io_req0_ready / io_req1_ready  output  1  requester N operand accepted this cycle.
REQ-007 io_req0_bits / io_req1_bits  input  32  IEEE-754 single-precision operand.
REQ-008 io_resp0_valid / io_resp1_valid  output  1  result available for requester N.
REQ-009 io_resp0_ready / io_resp1_ready  input  1  requester N takes result.
REQ-010 io_resp0_bits / io_resp1_bits  output  32  atan result, FIFO head.
REQ-011 io_atan_in  output  32  operand to Atan io_in.
REQ-012 io_atan_out  input  32  result from Atan io_out.

Function
REQ-013 Issue: at most one operand per cycle; handshake on reqN = valid & ready; ready asserted only for the granted requester; ready never depends on that requester's own bits.
REQ-014 Credit: cnt_N (0..FIFO_DEPTH) = in-flight + buffered results of N; requester N is eligible only when valid_N and cnt_N < FIFO_DEPTH.
REQ-015 cnt_N +1 on issue, -1 on resp pop (valid & ready), unchanged when both occur in the same cycle; never exceeds FIFO_DEPTH, never underflows.
REQ-016 Arbitration (default round-robin): one eligible requester is granted; both eligible -> grant the one not granted at the last issue; last_grant updates only on an issue.
REQ-017 io_atan_in = granted bits in an issue cycle, else 32'h0.
REQ-018 Tag pipeline: LATENCY-stage shift register of {valid, id}; issue cycle inserts {1, N}, else {0, x}; shifts every cycle unconditionally.
REQ-019 When a valid tag exits, io_atan_out is pushed unmodified into FIFO id at that edge; min request-to-resp_valid latency = LATENCY+1 cycles.
REQ-020 Each FIFO is FIFO_DEPTH entries, in order; push and pop in the same cycle allowed, including when full or empty-with-push (no bypass: a pushed value is visible the next cycle).
REQ-021 Credit rule guarantees no FIFO overflow; results are never dropped or reordered within a requester.
REQ-022 io_respN_valid = FIFO N non-empty; io_respN_bits = FIFO N head (32'h0 when empty).
REQ-023 Requesters are independent: a stalled io_respN_ready affects only requester N's eligibility.

Reset
REQ-024 Reset clears tags, FIFOs, cnt_N; last_grant resets to 1 so requester 0 wins first contention.
REQ-025 During and in the cycle after reset all outputs are 0: io_reqN_ready, io_respN_valid, io_respN_bits, io_atan_in.
REQ-026 Reset mid-operation discards all in-flight and buffered results; Atan outputs for pre-reset operands are ignored (tags invalid).

Configuration
REQ-027 Macro ATAN_ARB_FIXED_PRIO_EN: defined -> requester 0 always wins when both are eligible and last_grant is unused; undefined -> round-robin per REQ-016.

Verification
REQ-028 Single req0 bits 32'h3f800000 at cycle 0, resp0_ready=1 -> resp0_valid at cycle 18 with bits equal io_atan_out of cycle 17 (~32'h3f490fdb); req1 idle.
REQ-029 Both valid continuously, both resp_ready=1 -> grants 0,1,0,1,... one issue every cycle; each resp stream in issue order.
REQ-030 resp0_ready=0, req0 and req1 valid -> exactly 4 req0 issues then req0_ready stays 0, req1 issues every cycle; resp0_ready=1 for one pop -> exactly one further req0 issue.
REQ-031 cnt0=4 with resp0 pop and req0 valid in the same cycle -> no req0 issue that cycle (cnt0 becomes 3); issue next cycle.
REQ-032 Reset asserted 5 cycles after 3 issues -> all outputs 0, no resp_valid ever for those operands; first post-reset contention granted to requester 0.
REQ-033 ATAN_ARB_FIXED_PRIO_EN defined, both valid, credits free -> req0 granted every cycle until cnt0=4, then req1.
